// File: rtl/rd53_pix_pkg.sv
// Shared types and constants for the RD53 pixel ToT digitizer family.
package rd53_pix_pkg;

  localparam int DEF_TOT_W = 4;
  localparam int DEF_TS_W  = 9;
  // ToT code reserved for "no hit"; never emitted by a digitizer.
  localparam int TOT_NOHIT = 15;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_MEAS = 2'd1,
    SLOT_WAIT = 2'd2,
    SLOT_TRIG = 2'd3
  } slot_state_e;

  // Hit buffer slot record at the default widths.
  typedef struct packed {
    slot_state_e           state;
    logic                  trig_seen;
    logic [DEF_TS_W-1:0]   bx;
    logic [DEF_TOT_W-1:0]  tot;
  } slot_t;

endpackage

// File: rtl/rd53_sync_edge.sv
// N-flop synchronizer with registered level and rise/fall strobes.
// ACT_LOW inverts the pin so lvl is always the active-high logical state;
// the chain resets to the pin's idle value so no edge is seen at release.
module rd53_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_b,
  input  logic din,
  output logic lvl,
  output logic lvl_q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_pipe;

  // Synchronizer chain, idle value at reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) sync_pipe <= {STAGES{ACT_LOW}};
    else        sync_pipe <= {sync_pipe[STAGES-2:0], din};
  end

  assign lvl = sync_pipe[STAGES-1] ^ ACT_LOW;

  // Previous logical level, used for edge detection.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/rd53_pix_tot_digitizer.sv
// Per-pixel ToT digitizer: synchronizes the discriminator, measures ToT,
// buffers hits with their leading-edge BX and emits triggered hits.
module rd53_pix_tot_digitizer
  import rd53_pix_pkg::*;
#(
  parameter int TOT_W       = DEF_TOT_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int DEPTH       = 4,
  parameter int MAX_TOT     = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             outdis,
  input  logic             pix_en,
  input  logic [TS_W-1:0]  bx_cnt,
  input  logic [TS_W-1:0]  latency,
  input  logic             trigger,
  output logic             hit_or,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [TOT_W-1:0] hit_tot,
  output logic [TS_W-1:0]  hit_bx,
  output logic             ovf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Saturation is clamped below the reserved no-hit code.
  localparam logic [TOT_W-1:0] TOT_SAT =
    (MAX_TOT < TOT_NOHIT) ? TOT_W'(MAX_TOT) : TOT_W'(TOT_NOHIT - 1);

  typedef struct packed {
    slot_state_e       state;
    logic              trig_seen;
    logic [TS_W-1:0]   bx;
    logic [TOT_W-1:0]  tot;
  } slot_rec_t;

  logic disc, disc_q, disc_rise, disc_fall;

  rd53_sync_edge #(.STAGES(SYNC_STAGES), .ACT_LOW(1'b1)) u_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .din   (outdis),
    .lvl   (disc),
    .lvl_q (disc_q),
    .rise  (disc_rise),
    .fall  (disc_fall)
  );

  assign hit_or = disc_q;

  slot_rec_t [DEPTH-1:0] slots_q, slots_d;
  logic [DEPTH-1:0]      slot_exp;
  logic                  meas_on, meas_exp;
  logic [IDX_W-1:0]      meas_idx;
  logic [TOT_W-1:0]      meas_cnt;
  logic                  have_free, have_trig;
  logic [IDX_W-1:0]      free_idx, trig_idx;
  logic                  lead, alloc, trail, load;
  logic                  meas_exp_now, meas_decided, meas_trig;

  // Age of each slot's hit; modulo subtraction makes bx_cnt wrap transparent.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [TS_W-1:0] age;
    assign age         = bx_cnt - slots_q[g].bx;
    assign slot_exp[g] = (age == latency);
  end

  // Lowest-index FREE and TRIG slots.
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    have_trig = 1'b0;
    trig_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slots_q[i].state == SLOT_FREE) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
      if (slots_q[i].state == SLOT_TRIG) begin
        have_trig = 1'b1;
        trig_idx  = IDX_W'(i);
      end
    end
  end

  assign lead  = disc_rise & pix_en;
  assign alloc = lead & have_free;
  // Disabling the pixel mid-measurement closes the measurement early.
  assign trail = meas_on & (disc_fall | ~pix_en);
  assign load  = (~hit_valid | hit_ready) & have_trig;

  // The measuring slot expires at most once; the decision is latched until
  // the trailing edge.
  assign meas_exp_now = meas_on & ~meas_exp & slot_exp[meas_idx];
  assign meas_decided = meas_exp | meas_exp_now;
  assign meas_trig    = meas_exp ? slots_q[meas_idx].trig_seen : trigger;

  // Slot next-state: allocation, trailing edge, expiry and readout release.
  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < DEPTH; i++) begin
      case (slots_q[i].state)
        SLOT_FREE: begin
          if (alloc && free_idx == IDX_W'(i)) begin
            slots_d[i].state     = SLOT_MEAS;
            slots_d[i].trig_seen = 1'b0;
            slots_d[i].bx        = bx_cnt;
            slots_d[i].tot       = '0;
          end
        end
        SLOT_MEAS: begin
          if (trail) begin
            slots_d[i].tot       = meas_cnt;
            slots_d[i].trig_seen = meas_decided & meas_trig;
            slots_d[i].state     = !meas_decided ? SLOT_WAIT :
                                   (meas_trig ? SLOT_TRIG : SLOT_FREE);
          end else if (meas_exp_now) begin
            slots_d[i].trig_seen = trigger;
          end
        end
        SLOT_WAIT: begin
          if (slot_exp[i]) begin
            slots_d[i].trig_seen = trigger;
            slots_d[i].state     = trigger ? SLOT_TRIG : SLOT_FREE;
          end
        end
        SLOT_TRIG: begin
          if (load && trig_idx == IDX_W'(i)) slots_d[i].state = SLOT_FREE;
        end
        default: ;
      endcase
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) slots_q <= '0;
    else        slots_q <= slots_d;
  end

  // Measurement tracker: counter starts at 1 on the leading edge, saturates.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meas_on  <= 1'b0;
      meas_exp <= 1'b0;
      meas_idx <= '0;
      meas_cnt <= '0;
    end else if (alloc) begin
      meas_on  <= 1'b1;
      meas_exp <= 1'b0;
      meas_idx <= free_idx;
      meas_cnt <= TOT_W'(1);
    end else if (trail) begin
      meas_on  <= 1'b0;
      meas_exp <= 1'b0;
    end else if (meas_on) begin
      if (disc && meas_cnt != TOT_SAT) meas_cnt <= meas_cnt + 1'b1;
      if (meas_exp_now)                meas_exp <= 1'b1;
    end
  end

  // Output register with valid/ready hold, plus overflow strobe.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_valid <= 1'b0;
      hit_tot   <= '0;
      hit_bx    <= '0;
      ovf       <= 1'b0;
    end else begin
      ovf <= lead & ~have_free;
      if (!hit_valid || hit_ready) begin
        hit_valid <= have_trig;
        if (have_trig) begin
          hit_tot <= slots_q[trig_idx].tot;
          hit_bx  <= slots_q[trig_idx].bx;
        end
      end
    end
  end

endmodule

// File: tb/tb_rd53_pix_tot_digitizer.sv
// Directed bench for rd53_pix_tot_digitizer.
module tb_rd53_pix_tot_digitizer;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       outdis = 1'b1;
  logic       pix_en = 1'b1;
  logic [8:0] bx_cnt = '0;
  logic [8:0] latency = 9'd20;
  logic       trigger = 1'b0;
  logic       hit_ready = 1'b1;
  logic       hit_or, hit_valid, ovf;
  logic [3:0] hit_tot;
  logic [8:0] hit_bx;

  int n_chk = 0;
  int n_fail = 0;
  bit trig_map [512];

  typedef struct {int tot; int bx; int at;} rec_t;
  rec_t got_q[$];
  int   ovf_cnt = 0;

  rd53_pix_tot_digitizer #(
    .TOT_W(4), .TS_W(9), .DEPTH(4), .MAX_TOT(14), .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .outdis    (outdis),
    .pix_en    (pix_en),
    .bx_cnt    (bx_cnt),
    .latency   (latency),
    .trigger   (trigger),
    .hit_or    (hit_or),
    .hit_valid (hit_valid),
    .hit_ready (hit_ready),
    .hit_tot   (hit_tot),
    .hit_bx    (hit_bx),
    .ovf       (ovf)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Record every accepted hit and every overflow cycle.
  always @(negedge clk) begin
    if (rst_b) begin
      if (hit_valid && hit_ready)
        got_q.push_back('{tot: int'(hit_tot), bx: int'(hit_bx), at: int'(bx_cnt)});
      if (ovf) ovf_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bx_cnt  = bx_cnt + 9'd1;
    trigger = trig_map[bx_cnt];
  endtask

  task automatic set_bx(input int v);
    bx_cnt  = 9'(v);
    trigger = trig_map[bx_cnt];
  endtask

  task automatic wait_bx(input int v);
    int k;
    k = 0;
    while (bx_cnt != 9'(v) && k < 600) begin
      tick();
      k++;
    end
  endtask

  // Pin low for len cycles; disc leading edge lands on BX 'lead'.
  task automatic pulse(input int lead, input int len);
    wait_bx((lead - 2) & 511);
    outdis = 1'b0;
    repeat (len) tick();
    outdis = 1'b1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    outdis = 1'b1;
    pix_en = 1'b1;
    hit_ready = 1'b1;
    foreach (trig_map[i]) trig_map[i] = 1'b0;
    set_bx(0);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    tick();
    n_chk++; if (hit_or !== 1'b0) begin n_fail++; $display("FAIL reset_hit_or: got %b want 0", hit_or); end
    n_chk++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hit_valid: got %b want 0", hit_valid); end
    n_chk++; if (hit_tot !== 4'd0) begin n_fail++; $display("FAIL reset_hit_tot: got %0d want 0", hit_tot); end
    n_chk++; if (hit_bx !== 9'd0) begin n_fail++; $display("FAIL reset_hit_bx: got %0d want 0", hit_bx); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_basic_trig();
    int base;
    do_reset();
    latency = 9'd20;
    trig_map[120] = 1'b1;
    set_bx(90);
    base = got_q.size();
    wait_bx(98);
    outdis = 1'b0;
    tick(); tick();
    n_chk++; if (hit_or !== 1'b0) begin n_fail++; $display("FAIL hit_or_early: got %b want 0", hit_or); end
    tick();
    n_chk++; if (hit_or !== 1'b1) begin n_fail++; $display("FAIL hit_or_3cyc: got %b want 1", hit_or); end
    tick(); tick();
    outdis = 1'b1;
    wait_bx(130);
    n_chk++;
    if (got_q.size() - base !== 1) begin
      n_fail++; $display("FAIL basic_count: got %0d want 1", got_q.size() - base);
    end else begin
      n_chk++; if (got_q[base].tot !== 5) begin n_fail++; $display("FAIL basic_tot: got %0d want 5", got_q[base].tot); end
      n_chk++; if (got_q[base].bx !== 100) begin n_fail++; $display("FAIL basic_bx: got %0d want 100", got_q[base].bx); end
      n_chk++; if (got_q[base].at !== 122) begin n_fail++; $display("FAIL basic_time: got %0d want 122", got_q[base].at); end
    end
  endtask

  task automatic test_discard_reuse();
    int base, ovf0;
    int eb[4];
    eb = '{104, 108, 112, 121};
    do_reset();
    latency = 9'd20;
    trig_map[124] = 1'b1;
    trig_map[128] = 1'b1;
    trig_map[132] = 1'b1;
    trig_map[141] = 1'b1;
    set_bx(90);
    base = got_q.size();
    ovf0 = ovf_cnt;
    pulse(100, 2);
    pulse(104, 2);
    pulse(108, 2);
    pulse(112, 2);
    pulse(121, 2);
    wait_bx(150);
    n_chk++; if (ovf_cnt - ovf0 !== 0) begin n_fail++; $display("FAIL discard_ovf: got %0d want 0", ovf_cnt - ovf0); end
    n_chk++;
    if (got_q.size() - base !== 4) begin
      n_fail++; $display("FAIL discard_count: got %0d want 4", got_q.size() - base);
    end
    for (int k = 0; k < 4; k++) begin
      if (base + k < got_q.size()) begin
        n_chk++;
        if (got_q[base+k].bx !== eb[k] || got_q[base+k].tot !== 2) begin
          n_fail++;
          $display("FAIL discard_hit%0d: got tot=%0d bx=%0d want tot=2 bx=%0d",
                   k, got_q[base+k].tot, got_q[base+k].bx, eb[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int base;
    do_reset();
    latency = 9'd20;
    trig_map[320] = 1'b1;
    set_bx(290);
    base = got_q.size();
    pulse(300, 40);
    wait_bx(360);
    n_chk++;
    if (got_q.size() - base !== 1) begin
      n_fail++; $display("FAIL sat_count: got %0d want 1", got_q.size() - base);
    end else begin
      n_chk++; if (got_q[base].tot !== 14) begin n_fail++; $display("FAIL sat_tot: got %0d want 14", got_q[base].tot); end
      n_chk++; if (got_q[base].bx !== 300) begin n_fail++; $display("FAIL sat_bx: got %0d want 300", got_q[base].bx); end
      n_chk++; if (got_q[base].at !== 342) begin n_fail++; $display("FAIL sat_time: got %0d want 342", got_q[base].at); end
    end
  endtask

  task automatic test_overflow();
    int base, ovf0;
    int eb[4];
    eb = '{10, 16, 22, 28};
    do_reset();
    latency = 9'd200;
    trig_map[210] = 1'b1;
    trig_map[216] = 1'b1;
    trig_map[222] = 1'b1;
    trig_map[228] = 1'b1;
    trig_map[234] = 1'b1;
    set_bx(0);
    base = got_q.size();
    ovf0 = ovf_cnt;
    pulse(10, 1);
    pulse(16, 2);
    pulse(22, 3);
    pulse(28, 4);
    pulse(34, 1);
    wait_bx(40);
    n_chk++; if (ovf_cnt - ovf0 !== 1) begin n_fail++; $display("FAIL ovf_cycles: got %0d want 1", ovf_cnt - ovf0); end
    wait_bx(250);
    n_chk++;
    if (got_q.size() - base !== 4) begin
      n_fail++; $display("FAIL ovf_count: got %0d want 4", got_q.size() - base);
    end
    for (int k = 0; k < 4; k++) begin
      if (base + k < got_q.size()) begin
        n_chk++;
        if (got_q[base+k].bx !== eb[k] || got_q[base+k].tot !== k + 1) begin
          n_fail++;
          $display("FAIL ovf_hit%0d: got tot=%0d bx=%0d want tot=%0d bx=%0d",
                   k, got_q[base+k].tot, got_q[base+k].bx, k + 1, eb[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    latency = 9'd20;
    hit_ready = 1'b0;
    trig_map[30] = 1'b1;
    trig_map[36] = 1'b1;
    set_bx(0);
    base = got_q.size();
    pulse(10, 3);
    pulse(16, 5);
    wait_bx(33);
    n_chk++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_a: got %b want 1", hit_valid); end
    n_chk++; if (hit_tot !== 4'd3) begin n_fail++; $display("FAIL bp_tot_a: got %0d want 3", hit_tot); end
    n_chk++; if (hit_bx !== 9'd10) begin n_fail++; $display("FAIL bp_bx_a: got %0d want 10", hit_bx); end
    wait_bx(44);
    n_chk++; if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_b: got %b want 1", hit_valid); end
    n_chk++; if (hit_tot !== 4'd3) begin n_fail++; $display("FAIL bp_tot_b: got %0d want 3", hit_tot); end
    n_chk++; if (hit_bx !== 9'd10) begin n_fail++; $display("FAIL bp_bx_b: got %0d want 10", hit_bx); end
    wait_bx(45);
    hit_ready = 1'b1;
    wait_bx(50);
    n_chk++;
    if (got_q.size() - base !== 2) begin
      n_fail++; $display("FAIL bp_count: got %0d want 2", got_q.size() - base);
    end else begin
      n_chk++;
      if (got_q[base].tot !== 3 || got_q[base].bx !== 10 || got_q[base].at !== 45) begin
        n_fail++; $display("FAIL bp_first: got tot=%0d bx=%0d at=%0d want 3/10/45",
                           got_q[base].tot, got_q[base].bx, got_q[base].at);
      end
      n_chk++;
      if (got_q[base+1].tot !== 5 || got_q[base+1].bx !== 16 || got_q[base+1].at !== 46) begin
        n_fail++; $display("FAIL bp_second: got tot=%0d bx=%0d at=%0d want 5/16/46",
                           got_q[base+1].tot, got_q[base+1].bx, got_q[base+1].at);
      end
    end
  endtask

  task automatic test_bx_wrap();
    int base;
    do_reset();
    latency = 9'd15;
    trig_map[3] = 1'b1;
    set_bx(490);
    base = got_q.size();
    pulse(500, 3);
    wait_bx(10);
    n_chk++;
    if (got_q.size() - base !== 1) begin
      n_fail++; $display("FAIL wrap_count: got %0d want 1", got_q.size() - base);
    end else begin
      n_chk++;
      if (got_q[base].tot !== 3 || got_q[base].bx !== 500 || got_q[base].at !== 5) begin
        n_fail++; $display("FAIL wrap_hit: got tot=%0d bx=%0d at=%0d want 3/500/5",
                           got_q[base].tot, got_q[base].bx, got_q[base].at);
      end
    end
  endtask

  task automatic test_reset_mid_meas();
    int base;
    do_reset();
    latency = 9'd20;
    trig_map[80] = 1'b1;
    set_bx(40);
    base = got_q.size();
    wait_bx(58);
    outdis = 1'b0;
    repeat (6) tick();
    n_chk++; if (hit_or !== 1'b1) begin n_fail++; $display("FAIL mid_hit_or: got %b want 1", hit_or); end
    rst_b = 1'b0;
    outdis = 1'b1;
    #1;
    n_chk++; if (hit_or !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hit_or: got %b want 0", hit_or); end
    n_chk++; if (hit_valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got valid=%b ovf=%b want 0/0", hit_valid, ovf); end
    n_chk++; if (hit_tot !== 4'd0 || hit_bx !== 9'd0) begin n_fail++; $display("FAIL mid_rst_data: got tot=%0d bx=%0d want 0/0", hit_tot, hit_bx); end
    repeat (2) tick();
    rst_b = 1'b1;
    wait_bx(100);
    n_chk++; if (got_q.size() - base !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d hits want 0", got_q.size() - base); end
    n_chk++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", hit_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_trig();
    test_discard_reuse();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_bx_wrap();
    test_reset_mid_meas();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
